// File: rtl/sd_dat_pkg.sv
// Shared constants for the SD DAT-line serializer: frame geometry, CRC16
// polynomial, status token and FSM state encoding.
package sd_dat_pkg;

  localparam int unsigned DATA_BITS = 32;
  localparam int unsigned CRC_BITS  = 16;

  localparam logic [15:0] CRC_POLY  = 16'h1021;
  localparam logic [2:0]  STATUS_OK = 3'b010;

  // start + data + crc + end
  localparam int unsigned TX_FRAME_BITS = 1 + DATA_BITS + CRC_BITS + 1;
  localparam int unsigned STATUS_BITS   = 3;

  localparam logic [3:0] IDLE     = 4'd0;
  localparam logic [3:0] TX_START = 4'd1;
  localparam logic [3:0] TX_DATA  = 4'd2;
  localparam logic [3:0] TX_CRC   = 4'd3;
  localparam logic [3:0] TX_END   = 4'd4;
  localparam logic [3:0] TX_DONE  = 4'd5;
  localparam logic [3:0] ST_WAIT  = 4'd6;
  localparam logic [3:0] ST_BITS  = 4'd7;
  localparam logic [3:0] ST_END   = 4'd8;
  localparam logic [3:0] ST_BUSY  = 4'd9;
  localparam logic [3:0] RX_WAIT  = 4'd10;
  localparam logic [3:0] RX_DATA  = 4'd11;
  localparam logic [3:0] RX_CRC   = 4'd12;
  localparam logic [3:0] RX_END   = 4'd13;
  localparam logic [3:0] RX_DONE  = 4'd14;

endpackage

// File: rtl/sd_crc16.sv
// Serial CRC16 LFSR, one bit per enabled clock, MSB-first shift.
module sd_crc16
  import sd_dat_pkg::*;
#(
  parameter logic [15:0] POLY = sd_dat_pkg::CRC_POLY
) (
  input  logic        sd_clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        enable,
  input  logic        bit_in,
  output logic [15:0] crc
);

  logic [15:0] crc_q;
  logic [15:0] crc_d;
  logic        fb;

  always_comb begin
    fb    = bit_in ^ crc_q[15];
    crc_d = crc_q;
    if (clear) begin
      crc_d = '0;
    end else if (enable) begin
      crc_d = {crc_q[14:0], 1'b0} ^ (fb ? POLY : 16'h0000);
    end
  end

  always_ff @(posedge sd_clock) begin
    if (reset) begin
      crc_q <= '0;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/dat_serial_wrapper.sv
// SD DAT-line serializer/deserializer: frames one 32-bit word with CRC16 on
// write, decodes the CRC status token and busy, and receives/checks read frames.
module dat_serial_wrapper #(
  parameter logic [15:0] CRC_POLY  = sd_dat_pkg::CRC_POLY,
  parameter int unsigned DATA_BITS = sd_dat_pkg::DATA_BITS
) (
  input  logic                 sd_clock,
  input  logic                 reset,
  input  logic                 reset_wrapper,
  input  logic                 enable_pts,
  input  logic                 enable_stp,
  input  logic                 load_send,
  input  logic                 waiting_response,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 dat_in,
  output logic                 dat_out,
  output logic                 dat_oe,
  output logic                 transmission_complete,
  output logic                 reception_complete,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 crc_error,
  output logic [2:0]           crc_status,
  output logic                 write_error
);

  import sd_dat_pkg::*;

  localparam logic [5:0] DATA_LAST   = 6'(DATA_BITS - 1);
  localparam logic [5:0] CRC_LAST    = 6'(CRC_BITS - 1);
  localparam logic [5:0] STATUS_LAST = 6'(STATUS_BITS - 1);

  logic                 rst_any;
  logic [3:0]           state_q, state_d;
  logic [5:0]           cnt_q, cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 dat_out_q, dat_out_d;
  logic                 dat_oe_q, dat_oe_d;
  logic                 tc_q, tc_d;
  logic                 rc_q, rc_d;
  logic [DATA_BITS-1:0] data_out_q, data_out_d;
  logic                 crc_error_q, crc_error_d;
  logic [2:0]           crc_status_q, crc_status_d;
  logic                 write_error_q, write_error_d;
  logic                 mismatch_q, mismatch_d;

  logic                 crc_clear;
  logic                 crc_en;
  logic                 crc_bit;
  logic [15:0]          crc_val;

  assign rst_any = reset | reset_wrapper;

  sd_crc16 #(.POLY(CRC_POLY)) u_crc (
    .sd_clock (sd_clock),
    .reset    (rst_any),
    .clear    (crc_clear),
    .enable   (crc_en),
    .bit_in   (crc_bit),
    .crc      (crc_val)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    shift_d       = shift_q;
    dat_out_d     = dat_out_q;
    dat_oe_d      = dat_oe_q;
    tc_d          = tc_q;
    rc_d          = rc_q;
    data_out_d    = data_out_q;
    crc_error_d   = crc_error_q;
    crc_status_d  = crc_status_q;
    write_error_d = write_error_q;
    mismatch_d    = mismatch_q;
    crc_clear     = 1'b0;
    crc_en        = 1'b0;
    crc_bit       = 1'b0;

    case (state_q)
      IDLE: begin
        if (enable_pts && load_send) begin
          state_d   = TX_START;
          shift_d   = data_in;
          crc_clear = 1'b1;
          tc_d      = 1'b0;
          rc_d      = 1'b0;
        end else if (enable_stp) begin
          state_d = RX_WAIT;
        end
      end
      TX_START: begin
        dat_oe_d  = 1'b1;
        dat_out_d = 1'b0;
        cnt_d     = '0;
        state_d   = TX_DATA;
      end
      TX_DATA: begin
        dat_out_d = shift_q[DATA_BITS-1];
        shift_d   = {shift_q[DATA_BITS-2:0], 1'b0};
        crc_en    = 1'b1;
        crc_bit   = shift_q[DATA_BITS-1];
        cnt_d     = cnt_q + 6'd1;
        if (cnt_q == DATA_LAST) begin
          cnt_d   = '0;
          state_d = TX_CRC;
        end
      end
      TX_CRC: begin
        // CRC is frozen here; ~cnt walks bit 15 down to bit 0
        dat_out_d = crc_val[~cnt_q[3:0]];
        cnt_d     = cnt_q + 6'd1;
        if (cnt_q == CRC_LAST) begin
          state_d = TX_END;
        end
      end
      TX_END: begin
        dat_out_d = 1'b1;
        state_d   = TX_DONE;
      end
      TX_DONE: begin
        tc_d     = 1'b1;
        dat_oe_d = 1'b0;
        state_d  = waiting_response ? ST_WAIT : IDLE;
      end
      ST_WAIT: begin
        if (!dat_in) begin
          cnt_d   = '0;
          state_d = ST_BITS;
        end
      end
      ST_BITS: begin
        crc_status_d = {crc_status_q[1:0], dat_in};
        cnt_d        = cnt_q + 6'd1;
        if (cnt_q == STATUS_LAST) begin
          state_d = ST_END;
        end
      end
      ST_END: begin
        write_error_d = (crc_status_q != STATUS_OK) || !dat_in;
        state_d       = ST_BUSY;
      end
      ST_BUSY: begin
        if (dat_in) begin
          rc_d    = 1'b1;
          state_d = IDLE;
        end
      end
      RX_WAIT: begin
        if (!dat_in) begin
          cnt_d      = '0;
          crc_clear  = 1'b1;
          mismatch_d = 1'b0;
          state_d    = RX_DATA;
        end
      end
      RX_DATA: begin
        shift_d = {shift_q[DATA_BITS-2:0], dat_in};
        crc_en  = 1'b1;
        crc_bit = dat_in;
        cnt_d   = cnt_q + 6'd1;
        if (cnt_q == DATA_LAST) begin
          cnt_d   = '0;
          state_d = RX_CRC;
        end
      end
      RX_CRC: begin
        // compare each received CRC bit on the fly instead of buffering it
        if (dat_in != crc_val[~cnt_q[3:0]]) begin
          mismatch_d = 1'b1;
        end
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == CRC_LAST) begin
          state_d = RX_END;
        end
      end
      RX_END: begin
        if (!dat_in) begin
          mismatch_d = 1'b1;
        end
        state_d = RX_DONE;
      end
      RX_DONE: begin
        data_out_d  = shift_q;
        crc_error_d = mismatch_q;
        rc_d        = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (!enable_pts && (state_q inside {TX_START, TX_DATA, TX_CRC, TX_END})) begin
      state_d   = IDLE;
      dat_oe_d  = 1'b0;
      dat_out_d = 1'b1;
    end
    if (!enable_stp && (state_q inside {RX_WAIT, RX_DATA, RX_CRC, RX_END})) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge sd_clock) begin
    if (rst_any) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      shift_q       <= '0;
      dat_out_q     <= 1'b1;
      dat_oe_q      <= 1'b0;
      tc_q          <= 1'b0;
      rc_q          <= 1'b0;
      data_out_q    <= '0;
      crc_error_q   <= 1'b0;
      crc_status_q  <= '0;
      write_error_q <= 1'b0;
      mismatch_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      shift_q       <= shift_d;
      dat_out_q     <= dat_out_d;
      dat_oe_q      <= dat_oe_d;
      tc_q          <= tc_d;
      rc_q          <= rc_d;
      data_out_q    <= data_out_d;
      crc_error_q   <= crc_error_d;
      crc_status_q  <= crc_status_d;
      write_error_q <= write_error_d;
      mismatch_q    <= mismatch_d;
    end
  end

  assign dat_out               = dat_out_q;
  assign dat_oe                = dat_oe_q;
  assign transmission_complete = tc_q;
  assign reception_complete    = rc_q;
  assign data_out              = data_out_q;
  assign crc_error             = crc_error_q;
  assign crc_status            = crc_status_q;
  assign write_error           = write_error_q;

endmodule

// File: tb/tb_dat_serial_wrapper.sv
// Directed self-checking bench for dat_serial_wrapper: write framing, status
// token/busy decode, read CRC check, mid-frame clear and enable priority.
module tb_dat_serial_wrapper;

  logic        sd_clock;
  logic        reset;
  logic        reset_wrapper;
  logic        enable_pts;
  logic        enable_stp;
  logic        load_send;
  logic        waiting_response;
  logic [31:0] data_in;
  logic        dat_in;
  logic        dat_out;
  logic        dat_oe;
  logic        transmission_complete;
  logic        reception_complete;
  logic [31:0] data_out;
  logic        crc_error;
  logic [2:0]  crc_status;
  logic        write_error;

  int checks   = 0;
  int failures = 0;

  dat_serial_wrapper #(.CRC_POLY(16'h1021), .DATA_BITS(32)) dut (
    .sd_clock              (sd_clock),
    .reset                 (reset),
    .reset_wrapper         (reset_wrapper),
    .enable_pts            (enable_pts),
    .enable_stp            (enable_stp),
    .load_send             (load_send),
    .waiting_response      (waiting_response),
    .data_in               (data_in),
    .dat_in                (dat_in),
    .dat_out               (dat_out),
    .dat_oe                (dat_oe),
    .transmission_complete (transmission_complete),
    .reception_complete    (reception_complete),
    .data_out              (data_out),
    .crc_error             (crc_error),
    .crc_status            (crc_status),
    .write_error           (write_error)
  );

  initial sd_clock = 1'b0;
  always #5 sd_clock = ~sd_clock;

  task automatic step();
    @(posedge sd_clock);
    #1;
  endtask

  function automatic logic [15:0] crc_model(input logic [31:0] d);
    logic [15:0] c;
    logic        fb;
    c = 16'h0000;
    for (int i = 31; i >= 0; i--) begin
      fb = d[i] ^ c[15];
      c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return c;
  endfunction

  task automatic pulse_reset_wrapper();
    reset_wrapper = 1'b1;
    step();
    reset_wrapper = 1'b0;
  endtask

  // Sends one frame starting at edge T and checks every bit through T+51.
  task automatic tx_frame(input logic [31:0] d, input string name);
    logic [15:0] c;
    logic        exp_bit;
    c          = crc_model(d);
    enable_pts = 1'b1;
    data_in    = d;
    load_send  = 1'b1;
    step();
    load_send  = 1'b0;
    for (int k = 1; k <= 50; k++) begin
      step();
      if (k == 1) exp_bit = 1'b0;
      else if (k <= 33) exp_bit = d[33 - k];
      else if (k <= 49) exp_bit = c[49 - k];
      else exp_bit = 1'b1;
      checks++;
      if (dat_oe !== 1'b1 || dat_out !== exp_bit) begin
        failures++;
        $display("FAIL %s frame bit T+%0d: dat_oe=%b dat_out=%b expected dat_oe=1 dat_out=%b",
                 name, k, dat_oe, dat_out, exp_bit);
      end
      if (k == 1) begin
        checks++;
        if (transmission_complete !== 1'b0 || reception_complete !== 1'b0) begin
          failures++;
          $display("FAIL %s flags cleared at start: tc=%b rc=%b expected 0 0",
                   name, transmission_complete, reception_complete);
        end
      end
    end
    step();
    checks++;
    if (transmission_complete !== 1'b1 || dat_oe !== 1'b0) begin
      failures++;
      $display("FAIL %s done T+51: tc=%b dat_oe=%b expected tc=1 dat_oe=0",
               name, transmission_complete, dat_oe);
    end
  endtask

  // Drives start bit, 3 status bits, end bit, busy-low cycles then busy release.
  task automatic status_token(input logic [2:0] bits, input logic end_bit, input int busy,
                              input logic [2:0] exp_status, input logic exp_we,
                              input string name);
    dat_in = 1'b0;
    step();
    for (int i = 2; i >= 0; i--) begin
      dat_in = bits[i];
      step();
    end
    dat_in = end_bit;
    step();
    dat_in = 1'b0;
    for (int i = 0; i < busy; i++) step();
    checks++;
    if (reception_complete !== 1'b0) begin
      failures++;
      $display("FAIL %s busy: reception_complete=%b expected 0", name, reception_complete);
    end
    dat_in = 1'b1;
    step();
    checks++;
    if (reception_complete !== 1'b1 || crc_status !== exp_status || write_error !== exp_we) begin
      failures++;
      $display("FAIL %s status: rc=%b crc_status=%b write_error=%b expected rc=1 crc_status=%b write_error=%b",
               name, reception_complete, crc_status, write_error, exp_status, exp_we);
    end
  endtask

  task automatic rx_frame(input logic [31:0] d, input logic [15:0] c, input logic end_bit,
                          input logic exp_err, input string name);
    enable_pts = 1'b0;
    enable_stp = 1'b1;
    dat_in     = 1'b1;
    step();
    dat_in = 1'b0;
    step();
    for (int i = 31; i >= 0; i--) begin
      dat_in = d[i];
      step();
    end
    for (int i = 15; i >= 0; i--) begin
      dat_in = c[i];
      step();
    end
    dat_in = end_bit;
    step();
    dat_in = 1'b1;
    checks++;
    if (reception_complete !== 1'b0) begin
      failures++;
      $display("FAIL %s early: reception_complete=%b at R+49 expected 0", name, reception_complete);
    end
    step();
    checks++;
    if (reception_complete !== 1'b1 || data_out !== d || crc_error !== exp_err) begin
      failures++;
      $display("FAIL %s R+50: rc=%b data_out=%h crc_error=%b expected rc=1 data_out=%h crc_error=%b",
               name, reception_complete, data_out, crc_error, d, exp_err);
    end
    enable_stp = 1'b0;
    pulse_reset_wrapper();
    checks++;
    if (reception_complete !== 1'b0 || data_out !== 32'h0 || crc_error !== 1'b0) begin
      failures++;
      $display("FAIL %s cleared: rc=%b data_out=%h crc_error=%b expected 0 0 0",
               name, reception_complete, data_out, crc_error);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    checks++;
    if (dat_out !== 1'b1 || dat_oe !== 1'b0 || transmission_complete !== 1'b0 ||
        reception_complete !== 1'b0 || data_out !== 32'h0 || crc_error !== 1'b0 ||
        crc_status !== 3'b000 || write_error !== 1'b0) begin
      failures++;
      $display("FAIL reset: dat_out=%b dat_oe=%b tc=%b rc=%b data_out=%h crc_err=%b status=%b we=%b expected 1 0 0 0 0 0 000 0",
               dat_out, dat_oe, transmission_complete, reception_complete, data_out,
               crc_error, crc_status, write_error);
    end
  endtask

  task automatic test_write_zero();
    waiting_response = 1'b0;
    tx_frame(32'h0000_0000, "write_zero");
  endtask

  task automatic test_write_status_ok();
    waiting_response = 1'b1;
    tx_frame(32'hDEAD_BEEF, "write_deadbeef");
    status_token(3'b010, 1'b1, 5, 3'b010, 1'b0, "status_ok");
  endtask

  task automatic test_multiblock_status_err();
    tx_frame(32'h1357_9BDF, "write_multiblock");
    status_token(3'b101, 1'b1, 1, 3'b101, 1'b1, "status_101");
    waiting_response = 1'b0;
  endtask

  task automatic test_read();
    logic [15:0] c;
    c = crc_model(32'hDEAD_BEEF);
    pulse_reset_wrapper();
    rx_frame(32'hDEAD_BEEF, c, 1'b1, 1'b0, "read_good");
    rx_frame(32'hDEAD_BEEF, c ^ 16'h0001, 1'b1, 1'b1, "read_crc_flip");
    rx_frame(32'hDEAD_BEEF, c, 1'b0, 1'b1, "read_end_bit_low");
  endtask

  task automatic test_reset_wrapper_mid_tx();
    enable_pts = 1'b1;
    data_in    = 32'h1234_5678;
    load_send  = 1'b1;
    step();
    load_send = 1'b0;
    repeat (19) step();
    checks++;
    if (dat_oe !== 1'b1) begin
      failures++;
      $display("FAIL mid_tx T+19: dat_oe=%b expected 1", dat_oe);
    end
    pulse_reset_wrapper();
    checks++;
    if (dat_oe !== 1'b0 || dat_out !== 1'b1 || transmission_complete !== 1'b0 ||
        reception_complete !== 1'b0) begin
      failures++;
      $display("FAIL mid_tx clear: dat_oe=%b dat_out=%b tc=%b rc=%b expected 0 1 0 0",
               dat_oe, dat_out, transmission_complete, reception_complete);
    end
    step();
    tx_frame(32'hA5A5_0F0F, "after_clear");
  endtask

  task automatic test_simultaneous_enables();
    pulse_reset_wrapper();
    enable_stp = 1'b1;
    dat_in     = 1'b0;
    tx_frame(32'h0F0F_F0F0, "both_enables");
    checks++;
    if (reception_complete !== 1'b0) begin
      failures++;
      $display("FAIL both_enables rx idle: reception_complete=%b expected 0", reception_complete);
    end
    enable_stp = 1'b0;
    enable_pts = 1'b0;
    dat_in     = 1'b1;
    pulse_reset_wrapper();
  endtask

  initial begin
    reset            = 1'b1;
    reset_wrapper    = 1'b0;
    enable_pts       = 1'b0;
    enable_stp       = 1'b0;
    load_send        = 1'b0;
    waiting_response = 1'b0;
    data_in          = 32'h0;
    dat_in           = 1'b1;

    test_reset();
    test_write_zero();
    test_write_status_ok();
    test_multiblock_status_err();
    test_read();
    test_reset_wrapper_mid_tx();
    test_simultaneous_enables();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dat_serial_wrapper.md
# dat_serial_wrapper

Single-bit SD DAT-line serializer/deserializer that sits directly downstream of `dat_phys_controller`, between it and the DAT pad. On write it frames one 32-bit word as start bit, data, CRC16 and end bit, then decodes the card's CRC status token and busy period. On read it detects the start bit, deserializes 32 data bits, checks the CRC16 and presents the word. It raises `transmission_complete` and `reception_complete` back to the controller.

## Interface
- `CRC_POLY`, 16'h1021, CRC16-CCITT polynomial (x^16+x^12+x^5+1); CRC init value 16'h0000.
- `DATA_BITS`, 32, payload bits per frame (MSB first).
- `sd_clock`  in  1  clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high; full reset.
- `reset_wrapper`  in  1  synchronous clear from controller; same effect as `reset`.
- `enable_pts`  in  1  transmit path enable.
- `enable_stp`  in  1  receive path enable.
- `load_send`  in  1  start transmit; sampled with `enable_pts`.
- `waiting_response`  in  1  arms CRC-status/busy decode after transmit.
- `data_in`  in  32  word to send; latched at start.
- `dat_in`  in  1  DAT line from pad.
- `dat_out`  out  1  DAT line to pad.
- `dat_oe`  out  1  pad drive enable.
- `transmission_complete`  out  1  level; transmit frame finished.
- `reception_complete`  out  1  level; read frame or status+busy finished.
- `data_out`  out  32  received word.
- `crc_error`  out  1  read-frame CRC mismatch.
- `crc_status`  out  3  captured status token.
- `write_error`  out  1  `crc_status` != 3'b010.

## Operation
- Reset values (`reset` or `reset_wrapper`): `dat_out`=1, `dat_oe`=0, all flags 0, `data_out`=0, `crc_status`=0. FSM is in IDLE.
- FSM states:
  - IDLE
  - TX_START, TX_DATA, TX_CRC, TX_END, TX_DONE
  - ST_WAIT, ST_BITS, ST_END, ST_BUSY
  - RX_WAIT, RX_DATA, RX_CRC, RX_END, RX_DONE
- Leaving IDLE:
  - IDLE→TX_START when `enable_pts & load_send`. Latch `data_in`, clear CRC, clear both complete flags.
  - Else IDLE→RX_WAIT when `enable_stp`. TX has priority if both enables are set.
- Transmit path:
  - TX_DATA shifts 32 bits MSB first and feeds each bit to the CRC.
  - TX_CRC sends crc[15] first.
  - TX_END drives 1. Then TX_DONE sets `transmission_complete` and releases `dat_oe`.
- Status decode:
  - TX_DONE→ST_WAIT when `waiting_response`.
  - ST_WAIT waits for `dat_in`=0. ST_BITS captures 3 bits MSB first into `crc_status`.
  - ST_END expects 1; a 0 there still proceeds, with `write_error`=1.
  - ST_BUSY holds while `dat_in`=0. The first `dat_in`=1 sets `reception_complete` and goes to IDLE.
  - `write_error` = (`crc_status`!=3'b010).
- Multi-block write: in IDLE with `transmission_complete`/`reception_complete` set, a new `load_send` clears them and restarts. No `reset_wrapper` is needed.
- Receive path:
  - RX_WAIT waits for `dat_in`=0, then captures 32 bits in RX_DATA and 16 bits in RX_CRC.
  - RX_END samples the end bit; 0 there forces `crc_error`=1.
  - RX_DONE loads `data_out`, sets `crc_error` if computed CRC != received CRC, sets `reception_complete`, and holds until `reset_wrapper`.
- Dropping `enable_pts` mid-TX, or `enable_stp` mid-RX, aborts to IDLE: `dat_oe`=0, flags unchanged.
- Timeout is the controller's job; this block waits indefinitely.

## Timing
- Start sampled at edge T. `dat_oe`=1 from T+1 through T+50.
- `dat_out` sequence:
  - start bit 0 at T+1
  - data bits 31..0 at T+2..T+33
  - CRC bits 15..0 at T+34..T+49
  - end bit 1 at T+50
- `transmission_complete`=1 from T+51.
- Status token start bit seen at edge S:
  - status bits sampled S+1..S+3
  - end bit at S+4
  - busy sampled from S+5
  - `reception_complete` 1 cycle after the first busy-high sample.
- Read start bit seen at edge R:
  - data sampled R+1..R+32
  - CRC sampled R+33..R+48
  - end bit at R+49
  - `reception_complete`, `data_out` and `crc_error` valid at R+50.
- `reset_wrapper` takes effect at the next edge, overriding any state including mid-frame.

## Structure
- Package `sd_dat_pkg`:
  - state encoding
  - `DATA_BITS` and `CRC_BITS`=16
  - `CRC_POLY`
  - `STATUS_OK`=3'b010
  - frame lengths
- Sub-module `sd_crc16`, shared by TX and RX:
  - ports: `clear`, `enable`, `bit_in`, `crc[15:0]`
  - serial LFSR update: fb = `bit_in`^crc[15]; crc = {crc[14:0],1'b0} ^ (fb ? POLY : 0)
- One 6-bit bit counter and one 32-bit shift register serve both directions.

## Test plan
- Write 32'h0000_0000 with `load_send` at T → `dat_out` 0, then 48 zeros, then 1 at T+50; `transmission_complete` at T+51.
- Write 32'hDEAD_BEEF then status token 0,0,1,0,1 plus 5 busy-low cycles → `crc_status`=3'b010, `write_error`=0; `reception_complete` 1 cycle after `dat_in` returns high.
- Status token 101 → `crc_status`=3'b101, `write_error`=1.
- Read frame carrying 32'hDEAD_BEEF with the `sd_crc16` model's correct CRC → `data_out`=32'hDEAD_BEEF, `crc_error`=0 at R+50. The same frame with CRC bit 0 flipped → `crc_error`=1.
- `reset_wrapper` at T+20 of a transmit → `dat_oe`=0 and `dat_out`=1 next cycle, IDLE, flags 0. A new `load_send` then sends a full frame.
- `enable_pts`, `enable_stp` and `load_send` asserted together → transmit starts; the receive path stays idle.
